// File: rtl/tick_period_meter.sv
// tick_period_meter: measures rise-to-rise tick period with tolerance, lock and stall flags; TICK_METER_SYNC_EN adds a 2-flop input synchronizer
module tick_period_meter #(
  parameter int CNT_W      = 21,
  parameter int EXPECTED   = 500000,
  parameter int TOL        = 1000,
  parameter int TIMEOUT    = 1000000,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout_flag
);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W:0] LO = (CNT_W+1)'(EXPECTED > TOL ? EXPECTED - TOL : 0);
  localparam logic [CNT_W:0] HI = (CNT_W+1)'(EXPECTED + TOL);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STALLED} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             tick_s, tick_q, rise, tol_d;

`ifdef TICK_METER_SYNC_EN
  logic [1:0] sync_q;
  // two-flop synchronizer for an asynchronous tick source
  always_ff @(posedge clk_in or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], tick_in};
  assign tick_s = sync_q[1];
`else
  assign tick_s = tick_in;
`endif

  // saturating count doubles as the period value (cnt+1, all-ones if saturated)
  always_comb begin
    cnt_d      = &cnt_q ? cnt_q : cnt_q + 1'b1;
    tol_d      = ({1'b0, cnt_d} >= LO) && ({1'b0, cnt_d} <= HI);
    lock_cnt_d = tol_d ? (lock_cnt_q == LOCK_MAX ? lock_cnt_q : lock_cnt_q + 1'b1) : '0;
    rise       = tick_s & ~tick_q;
  end

  // measurement FSM with registered outputs; a rise beats the timeout in the same cycle
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state_q      <= WAIT_FIRST;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
      tick_q       <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      tick_q       <= tick_s;
      period_valid <= 1'b0;
      case (state_q)
        MEASURE:
          if (rise) begin
            period_out   <= cnt_d;
            period_valid <= 1'b1;
            in_tol       <= tol_d;
            lock_cnt_q   <= lock_cnt_d;
            locked       <= lock_cnt_d == LOCK_MAX;
            timeout_flag <= 1'b0;
            cnt_q        <= '0;
          end else if (cnt_q == TO_M1) begin
            state_q      <= STALLED;
            timeout_flag <= 1'b1;
            locked       <= 1'b0;
            lock_cnt_q   <= '0;
            in_tol       <= 1'b0;
          end else
            cnt_q <= cnt_d;
        WAIT_FIRST, STALLED:
          if (rise) begin
            cnt_q   <= '0;
            state_q <= MEASURE;
          end
        default: state_q <= WAIT_FIRST;
      endcase
    end
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: directed and random tick trains checked against a timestamp-based reference model
module tb_tick_period_meter;
  localparam int EXP = 100, TOL = 2, TMO = 200, LC = 3;
  localparam int LO = EXP > TOL ? EXP - TOL : 0, HI = EXP + TOL;
`ifdef TICK_METER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic        clk_in = 0, rst = 1, tick_in = 0;
  logic [20:0] period_out;
  logic        period_valid, in_tol, locked, timeout_flag;

  tick_period_meter #(.CNT_W(21), .EXPECTED(EXP), .TOL(TOL), .TIMEOUT(TMO), .LOCK_COUNT(LC)) dut (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .period_out(period_out),
    .period_valid(period_valid), .in_tol(in_tol), .locked(locked), .timeout_flag(timeout_flag)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0;
  int k = 0, mode = 0, t0 = 0, lockn = 0, e_period = 0;
  bit e_valid, e_tol, e_locked, e_to;
  logic a0, a1, a2, s_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    mode = 0; lockn = 0; e_period = 0;
    e_valid = 0; e_tol = 0; e_locked = 0; e_to = 0;
    a0 = 0; a1 = 0; a2 = 0; s_prev = 0;
  endtask

  // mode 0: no reference edge, 1: measuring since t0, 2: stalled
  task automatic model_step(input logic v);
    logic s, r;
    int el;
    a2 = a1; a1 = a0; a0 = v;
    s = D == 0 ? a0 : a2;
    r = s && !s_prev;
    s_prev = s;
    k++;
    e_valid = 0;
    if (mode == 1) begin
      el = k - t0;
      if (r) begin
        e_period = el;
        e_valid  = 1;
        e_tol    = el >= LO && el <= HI;
        lockn    = e_tol ? (lockn < LC ? lockn + 1 : LC) : 0;
        e_locked = lockn == LC;
        e_to     = 0;
        t0       = k;
      end else if (el == TMO) begin
        mode = 2; e_to = 1; e_locked = 0; lockn = 0; e_tol = 0;
      end
    end else if (r) begin
      mode = 1;
      t0   = k;
    end
  endtask

  task automatic cyc(input logic v);
    tick_in = v;
    @(posedge clk_in);
    #1;
    if (rst) model_reset();
    else model_step(v);
    chk("period_out", period_out, e_period);
    chk("period_valid", period_valid, e_valid);
    chk("in_tol", in_tol, e_tol);
    chk("locked", locked, e_locked);
    chk("timeout_flag", timeout_flag, e_to);
    @(negedge clk_in);
  endtask

  task automatic pulse(input int w, input int iv);
    for (int i = 0; i < iv; i++) cyc(i < w);
  endtask

  task automatic do_reset;
    #2 rst = 1;
    #1;
    chk("async_rst_period", period_out, 0);
    chk("async_rst_valid", period_valid, 0);
    chk("async_rst_tol", in_tol, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_timeout", timeout_flag, 0);
    cyc(0);
    cyc(0);
    rst = 0;
  endtask

  initial begin
    model_reset();
    cyc(0);
    cyc(0);
    rst = 0;
    // nominal lock
    repeat (5) pulse(1, 100);
    chk("s1_period", period_out, 100);
    chk("s1_in_tol", in_tol, 1);
    chk("s1_locked", locked, 1);
    // tolerance edges 98, 102, 97, 103
    pulse(1, 98); pulse(1, 102); pulse(1, 97); pulse(1, 103); pulse(1, 50);
    chk("s2_period", period_out, 103);
    chk("s2_in_tol", in_tol, 0);
    chk("s2_locked", locked, 0);
    // relock then stall
    repeat (4) pulse(1, 100);
    repeat (150) cyc(0);
    chk("s3_timeout", timeout_flag, 1);
    chk("s3_locked", locked, 0);
    pulse(1, 100);
    pulse(1, 60);
    chk("s3_period", period_out, 100);
    chk("s3_timeout_clr", timeout_flag, 0);
    // interval exactly at the timeout threshold
    pulse(1, 200);
    pulse(1, 50);
    chk("s4_period", period_out, 200);
    chk("s4_in_tol", in_tol, 0);
    chk("s4_timeout", timeout_flag, 0);
    // held-high tick, then reset mid-interval
    pulse(10, 100);
    pulse(1, 40);
    chk("s5_period", period_out, 100);
    do_reset();
    pulse(1, 100);
    chk("s5_no_valid_after_rst", period_out, 0);
    pulse(1, 30);
    // random trains with occasional resets
    repeat (30) begin
      int iv, w;
      iv = $urandom_range(95, 210);
      w  = $urandom_range(1, 8);
      if ($urandom_range(0, 14) == 0) do_reset();
      pulse(w, iv);
    end
    repeat (5) cyc(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures the interval, in clk_in cycles, between successive rising edges of a periodic tick input.
- Reports each measured period, whether it is within tolerance of an expected value, a lock indication, and a stall timeout.
- Sits downstream of the slow-tick generator as its checker and monitor. Also usable on any external pulse train.

Parameters:
- CNT_W, 21, width of the period counter and of period_out.
- EXPECTED, 500000, nominal period in cycles.
- TOL, 1000, allowed absolute deviation from EXPECTED, in cycles, inclusive.
- TIMEOUT, 1000000, cycles without an edge before a stall is declared. Must be <= 2^CNT_W-1.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked.

Ports:
- clk_in  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick_in  input  1  tick to be measured; level, edge-detected internally
- period_out  output  CNT_W  last measured period in cycles
- period_valid  output  1  one-cycle pulse when period_out updates
- in_tol  output  1  last period within EXPECTED±TOL
- locked  output  1  LOCK_COUNT consecutive in-tolerance periods seen
- timeout_flag  output  1  stall detected; sticky until the next valid period

Behaviour:
- Clocking and reset: one clock, clk_in. rst is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - State = WAIT_FIRST, counters 0, tick_d 0.
- Edge detect: rise = tick_in & ~tick_d, where tick_d is tick_in registered. A tick held high counts as one edge.
- States:
  - WAIT_FIRST: counter idle. On rise: cnt<=0, go to MEASURE. No period_valid is generated.
  - MEASURE: cnt increments each cycle and saturates at all-ones. On rise:
    - period_out<=cnt+1.
    - period_valid=1 for exactly one cycle.
    - in_tol updated.
    - cnt<=0.
    - timeout_flag<=0.
    - Stay in MEASURE.
    - Latency: outputs are registered on the clock edge that samples the rise, so they are visible the cycle after rise is asserted.
    - Period definition: rises at samples n and n+P give period_out=P.
  - MEASURE timeout: when cnt+1==TIMEOUT and there is no rise that cycle:
    - go to STALLED.
    - timeout_flag<=1.
    - locked<=0, lock counter<=0.
    - in_tol<=0.
  - STALLED: counter frozen. On rise: cnt<=0, go to MEASURE, no period_valid. The first interval after a stall is not trusted. timeout_flag holds until the next period_valid.
- Simultaneous rise and timeout threshold in the same cycle: rise wins. The period is reported and no timeout occurs.
- Tolerance:
  - in_tol = (period >= EXPECTED-TOL) && (period <= EXPECTED+TOL).
  - Compare at CNT_W+1 bits so no wrap occurs.
  - If EXPECTED<TOL, the lower bound clamps to 0.
- Lock:
  - The lock counter (width ceil(log2(LOCK_COUNT+1))) increments on each in-tolerance period_valid and saturates at LOCK_COUNT.
  - locked=1 when the counter reaches LOCK_COUNT.
  - An out-of-tolerance period clears the counter and locked in the same update as period_valid.
- Reset mid-measurement aborts immediately to WAIT_FIRST. No partial period is reported.
- A saturated cnt is reported as all-ones. This is unreachable when TIMEOUT fits in CNT_W.

Optional Feature:
- Macro: TICK_METER_SYNC_EN.
- Defined:
  - tick_in passes through a 2-flop synchronizer (reset 0) before edge detect.
  - Edge-to-output latency grows by 2 cycles.
  - Measured periods are unchanged.
  - Required for tick_in from an asynchronous source.
- Undefined: tick_in is assumed synchronous to clk_in and feeds the edge detector directly.

Test Plan:
Test parameters for all scenarios: EXPECTED=100, TOL=2, TIMEOUT=200, LOCK_COUNT=3.
- 1. Nominal lock: 1-cycle pulses every 100 cycles, 5 pulses.
  - First pulse: no period_valid.
  - Pulses 2-5: period_out=100, in_tol=1.
  - locked rises with the 4th pulse's period_valid, i.e. the 3rd valid period.
- 2. Tolerance edges: intervals 98, 102, 97, 103.
  - in_tol = 1, 1, 0, 0.
  - locked and the lock counter clear on the 97.
- 3. Stall: locked, then tick_in held 0.
  - timeout_flag=1 and locked=0 exactly 200 cycles after the last rise.
  - Next pulse: no period_valid.
  - Following pulse after 100 cycles: period_valid, period_out=100, timeout_flag=0.
- 4. Tie: interval exactly 200 cycles.
  - Period reported as 200, in_tol=0, timeout_flag stays 0.
- 5. Held-high tick and reset:
  - tick_in high for 10 cycles counts as one edge.
  - rst asserted mid-interval: outputs 0 asynchronously, the next pulse gives no period_valid.
- 6. With TICK_METER_SYNC_EN: repeat scenario 1. Values are identical, and period_valid is delayed by 2 cycles relative to the run without the macro.
